dcache_port_arbiter: RTL and testbench
======================================

// Module: dcache_port_arbiter
// PURPOSE
//  Shares the single data-cache port between two requesters:
//   - the stage-1 controller (CPU load/store via MAR/MDR)
//   - the input-device DMA channel.
//  Two-way round-robin with a registered command path: it latches the winner's command,
//  holds the cache enable until ch_hit, then pulses ack to the winner.
//  A miss-wait timeout guard prevents a lost hit from hanging the pipeline.
// PARAMETERS
//  AW        8   address width (cache address bus)
//  DW        8   data width
//  MAX_WAIT  31  cycles in ACCESS without ch_hit before timeout; wait_cnt is 5 bits
// PORTS
//  g_clk        in   1   global clock, rising edge
//  g_clr        in   1   global reset, asynchronous, active-low
//  cpu_req      in   1   CPU request, level; held until cpu_ack seen
//  cpu_rw       in   1   0=read, 1=write
//  cpu_addr     in   AW  CPU address
//  cpu_wdata    in   DW  CPU write data
//  cpu_ack      out  1   one-cycle completion pulse to CPU
//  cpu_rdata    out  DW  CPU read data, valid with cpu_ack
//  dma_req      in   1   DMA request, level; same rules as cpu_req
//  dma_rw       in   1   0=read, 1=write
//  dma_addr     in   AW  DMA address
//  dma_wdata    in   DW  DMA write data
//  dma_ack      out  1   one-cycle completion pulse to DMA
//  dma_rdata    out  DW  DMA read data, valid with dma_ack
//  ch_en        out  1   cache enable
//  ch_rw        out  1   cache direction, 0=read, 1=write
//  ch_addr      out  AW  cache address
//  ch_wdata     out  DW  cache write data
//  ch_rdata     in   DW  cache read data
//  ch_hit       in   1   cache access complete, sampled only while ch_en=1
//  err_clr      in   1   synchronous clear of timeout_err
//  busy         out  1   1 in any state other than IDLE
//  owner        out  1   current or last grant, 0=CPU, 1=DMA
//  timeout_err  out  1   sticky; set when an access times out
//  wait_cnt     out  5   cycles spent in the current ACCESS
// BEHAVIOUR
//  Reset (g_clr=0, async):
//   - state=IDLE; all outputs 0, including rdata regs and wait_cnt.
//   - owner=1, so the first tie goes to CPU.
//   - An in-flight access is abandoned and ch_en drops immediately.
//   - A requester still holding req after reset is re-arbitrated normally.
//  FSM (registered outputs):
//   - IDLE
//     - No request: stay in IDLE.
//     - One request: grant it.
//     - Both requesting: grant the requester that is NOT owner (round-robin).
//     - On grant: latch rw/addr/wdata into command regs, update owner, wait_cnt=0, go ACCESS.
//   - ACCESS
//     - ch_en=1; ch_rw/ch_addr/ch_wdata come from the latched regs and stay stable.
//     - wait_cnt increments every cycle.
//     - ch_hit=1: on a read, capture ch_rdata into owner's rdata reg; go RESP.
//     - Otherwise, if wait_cnt==MAX_WAIT: set timeout_err; a read loads rdata=0; go RESP.
//   - RESP
//     - ch_en=0; owner's ack=1 for exactly this cycle; next state IDLE.
//  Latency: req sampled in IDLE → ack two cycles later for a zero-wait hit; add N for N miss cycles.
//  Handshake rules:
//   - Requester keeps req and fields stable until the edge where it sees ack=1.
//   - It deasserts req at that edge; req still high in IDLE counts as a new request.
//   - Changes to the non-granted requester's inputs during ACCESS/RESP are ignored.
//   - A write leaves that requester's rdata unchanged.
//  Boundaries:
//   - ch_hit while ch_en=0 is ignored.
//   - ch_hit in the same cycle wait_cnt==MAX_WAIT counts as a hit; no error.
//   - err_clr and a new timeout in the same cycle: set wins.
//   - wait_cnt saturates at MAX_WAIT; it never wraps.
//   - cpu_ack and dma_ack are never high together.
// STRUCTURE
//  Shared package proc_pkg:
//   - ARB_IDLE / ARB_ACCESS / ARB_RESP state encodings
//   - OWN_CPU=0, OWN_DMA=1
//   - CH_READ=0, CH_WRITE=1
//  Sub-module arb_rr2: combinational 2-way round-robin picker.
//   - Inputs: req[1:0] and last owner. Outputs: gnt_valid, gnt_id.
//  Command latch, FSM, wait counter and rdata regs stay in the top module.
// TESTING
//  1. Reset, then CPU read addr 8'h05; cache hits on the first ACCESS cycle with 8'hA7
//     → cpu_ack two cycles after req, cpu_rdata=8'hA7, dma_ack=0.
//  2. cpu_req and dma_req high in the same IDLE cycle after reset → CPU served first,
//     then DMA; repeat → CPU again (alternation; no starvation).
//  3. DMA write 8'h3C to addr 8'h0E with ch_hit delayed 4 cycles
//     → ch_en high 5 cycles, ch_wdata=8'h3C stable, dma_ack on the following cycle, timeout_err=0.
//  4. CPU read, ch_hit never asserts → after 31 cycles timeout_err=1, cpu_ack pulses,
//     cpu_rdata=0; err_clr pulse → timeout_err=0.
//  5. g_clr low mid-ACCESS with CPU req still high → ch_en=0 and busy=0 immediately;
//     after release CPU is re-granted and completes.
//  6. ch_hit pulsed while IDLE, then a CPU write → no spurious ack;
//     cpu_rdata keeps its prior value after the write.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared encodings for the data-cache port arbiter: FSM states, owner ids and
// cache direction codes.
package proc_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_DMA  = 1'b1;

  localparam logic CH_READ  = 1'b0;
  localparam logic CH_WRITE = 1'b1;

  localparam int unsigned WaitW = 5;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker. On a tie the requester that did not win last time
// is chosen; a lone requester always wins.
module arb_rr2 import proc_pkg::*; (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  // Pick a winner from the current request levels and the last owner
  always_comb begin
    gnt_valid_o = |req_i;
    gnt_id_o    = OWN_CPU;
    if (&req_i) begin
      gnt_id_o = ~last_i;
    end else if (req_i[OWN_DMA]) begin
      gnt_id_o = OWN_DMA;
    end
  end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single data-cache port between the CPU stage-1 controller and the
// input DMA channel. The winner's command is latched, the cache is enabled until
// ch_hit (or a miss-wait timeout), then the winner gets a one-cycle ack.
module dcache_port_arbiter import proc_pkg::*; #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_WAIT = 31
) (
  input  logic             g_clk,
  input  logic             g_clr,
  input  logic             cpu_req,
  input  logic             cpu_rw,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [DW-1:0]    cpu_wdata,
  output logic             cpu_ack,
  output logic [DW-1:0]    cpu_rdata,
  input  logic             dma_req,
  input  logic             dma_rw,
  input  logic [AW-1:0]    dma_addr,
  input  logic [DW-1:0]    dma_wdata,
  output logic             dma_ack,
  output logic [DW-1:0]    dma_rdata,
  output logic             ch_en,
  output logic             ch_rw,
  output logic [AW-1:0]    ch_addr,
  output logic [DW-1:0]    ch_wdata,
  input  logic [DW-1:0]    ch_rdata,
  input  logic             ch_hit,
  input  logic             err_clr,
  output logic             busy,
  output logic             owner,
  output logic             timeout_err,
  output logic [WaitW-1:0] wait_cnt
);

  localparam logic [WaitW-1:0] MaxWait = WaitW'(MAX_WAIT);

  arb_state_e       state_q;
  logic             owner_q;
  logic             cmd_rw_q;
  logic [AW-1:0]    cmd_addr_q;
  logic [DW-1:0]    cmd_wdata_q;
  logic             ch_en_q;
  logic             cpu_ack_q;
  logic             dma_ack_q;
  logic [DW-1:0]    cpu_rdata_q;
  logic [DW-1:0]    dma_rdata_q;
  logic             err_q;
  logic [WaitW-1:0] wait_q;

  logic gnt_valid;
  logic gnt_id;

  arb_rr2 u_rr2 (
    .req_i      ({dma_req, cpu_req}),
    .last_i     (owner_q),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id)
  );

  // Arbitration FSM with command latch, wait counter, rdata and error registers
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_DMA;  // first tie goes to the CPU
      cmd_rw_q    <= CH_READ;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      ch_en_q     <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      err_q       <= 1'b0;
      wait_q      <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      // Clear first so a timeout later in this block overrides it
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (gnt_valid) begin
            owner_q     <= gnt_id;
            cmd_rw_q    <= (gnt_id == OWN_DMA) ? dma_rw    : cpu_rw;
            cmd_addr_q  <= (gnt_id == OWN_DMA) ? dma_addr  : cpu_addr;
            cmd_wdata_q <= (gnt_id == OWN_DMA) ? dma_wdata : cpu_wdata;
            wait_q      <= '0;
            ch_en_q     <= 1'b1;
            state_q     <= ARB_ACCESS;
          end
        end
        ARB_ACCESS: begin
          if (wait_q != MaxWait) wait_q <= wait_q + 1'b1;
          if (ch_hit || (wait_q == MaxWait)) begin
            if (cmd_rw_q != CH_WRITE) begin
              // A hit returns cache data; a timed-out read returns zero
              if (owner_q == OWN_DMA) dma_rdata_q <= ch_hit ? ch_rdata : '0;
              else                    cpu_rdata_q <= ch_hit ? ch_rdata : '0;
            end
            if (!ch_hit) err_q <= 1'b1;
            if (owner_q == OWN_DMA) dma_ack_q <= 1'b1;
            else                    cpu_ack_q <= 1'b1;
            ch_en_q <= 1'b0;
            state_q <= ARB_RESP;
          end
        end
        ARB_RESP: state_q <= ARB_IDLE;
        default:  state_q <= ARB_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != ARB_IDLE);
  assign owner       = owner_q;
  assign ch_en       = ch_en_q;
  assign ch_rw       = cmd_rw_q;
  assign ch_addr     = cmd_addr_q;
  assign ch_wdata    = cmd_wdata_q;
  assign cpu_ack     = cpu_ack_q;
  assign dma_ack     = dma_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign dma_rdata   = dma_rdata_q;
  assign timeout_err = err_q;
  assign wait_cnt    = wait_q;

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Bench for dcache_port_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model.
module tb_dcache_port_arbiter;

  localparam int unsigned AW       = 8;
  localparam int unsigned DW       = 8;
  localparam int unsigned MAX_WAIT = 31;

  logic          g_clk = 1'b0;
  logic          g_clr;
  logic          cpu_req, cpu_rw, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_rw, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic          ch_en, ch_rw, ch_hit, err_clr, busy, owner, timeout_err;
  logic [AW-1:0] ch_addr;
  logic [DW-1:0] ch_wdata, ch_rdata;
  logic [4:0]    wait_cnt;

  // Cache contents; the cache answers with whatever sits at the requested address
  logic [DW-1:0] mem [256];
  assign ch_rdata = mem[ch_addr];

  always #5 g_clk = ~g_clk;

  dcache_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .g_clk(g_clk), .g_clr(g_clr),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_rw(dma_rw), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ch_en(ch_en), .ch_rw(ch_rw), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
    .ch_rdata(ch_rdata), .ch_hit(ch_hit), .err_clr(err_clr),
    .busy(busy), .owner(owner), .timeout_err(timeout_err), .wait_cnt(wait_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: one transaction in flight at most
  bit            m_on;       // a granted access is waiting for completion
  bit            m_who;      // 0=CPU 1=DMA
  bit            m_last;     // last grant
  bit            m_rw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_acc;      // access cycles elapsed for the current transaction
  int            m_free;     // first cycle index at which a new grant can happen
  bit            e_cpu_ack, e_dma_ack, e_busy, e_err;
  logic [DW-1:0] e_cpu_rd, e_dma_rd;
  logic [4:0]    e_wait;
  int            hit_delay;
  int            ack_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_on = 0; m_who = 0; m_last = 1; m_rw = 0; m_addr = '0; m_wdata = '0;
    m_acc = 0; m_free = 0;
    e_cpu_ack = 0; e_dma_ack = 0; e_busy = 0; e_err = 0;
    e_cpu_rd = '0; e_dma_rd = '0; e_wait = '0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_edge();
    bit done = 0;
    bit tmo  = 0;
    e_cpu_ack = 0;
    e_dma_ack = 0;
    if (m_on) begin
      m_acc++;
      if (ch_hit) done = 1;
      else if (m_acc - 1 == int'(MAX_WAIT)) begin done = 1; tmo = 1; end
      e_wait = (m_acc > int'(MAX_WAIT)) ? 5'(MAX_WAIT) : 5'(m_acc);
      if (done) begin
        if (!m_rw) begin
          if (m_who) e_dma_rd = tmo ? '0 : mem[m_addr];
          else       e_cpu_rd = tmo ? '0 : mem[m_addr];
        end else if (!tmo) begin
          mem[m_addr] = m_wdata;
        end
        if (m_who) e_dma_ack = 1; else e_cpu_ack = 1;
        m_on   = 0;
        m_free = cyc + 2;
      end
    end else if (cyc >= m_free && (cpu_req || dma_req)) begin
      m_who   = (cpu_req && dma_req) ? !m_last : dma_req;
      m_last  = m_who;
      m_rw    = m_who ? dma_rw    : cpu_rw;
      m_addr  = m_who ? dma_addr  : cpu_addr;
      m_wdata = m_who ? dma_wdata : cpu_wdata;
      m_acc   = 0;
      e_wait  = '0;
      m_on    = 1;
    end
    e_err  = tmo ? 1'b1 : (err_clr ? 1'b0 : e_err);
    e_busy = m_on || done;
  endtask

  task automatic check_all();
    chk("ch_en",       32'(ch_en),       32'(m_on));
    chk("busy",        32'(busy),        32'(e_busy));
    chk("cpu_ack",     32'(cpu_ack),     32'(e_cpu_ack));
    chk("dma_ack",     32'(dma_ack),     32'(e_dma_ack));
    chk("ack_excl",    32'(cpu_ack & dma_ack), 32'd0);
    chk("cpu_rdata",   32'(cpu_rdata),   32'(e_cpu_rd));
    chk("dma_rdata",   32'(dma_rdata),   32'(e_dma_rd));
    chk("timeout_err", 32'(timeout_err), 32'(e_err));
    chk("wait_cnt",    32'(wait_cnt),    32'(e_wait));
    chk("owner",       32'(owner),       32'(m_last));
    if (m_on) begin
      chk("ch_rw",    32'(ch_rw),    32'(m_rw));
      chk("ch_addr",  32'(ch_addr),  32'(m_addr));
      chk("ch_wdata", 32'(ch_wdata), 32'(m_wdata));
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
    cyc++;
    if (!g_clr) model_reset();
    else        model_edge();
    check_all();
  endtask

  // Run until both requesters are served; the cache hits after `delay` wait cycles
  task automatic serve(input int bound, input int delay);
    int k = 0;
    ch_hit = m_on && (m_acc == delay);
    while (k < bound && (cpu_req || dma_req || m_on || e_busy)) begin
      step();
      k++;
      if (e_cpu_ack) begin ack_q.push_back(0); cpu_req = 0; end
      if (e_dma_ack) begin ack_q.push_back(1); dma_req = 0; end
      ch_hit = m_on && (m_acc == delay);
    end
    chk("serve_within_bound", 32'(k < bound), 32'd1);
    ch_hit = 0;
  endtask

  task automatic drive_random();
    if (e_cpu_ack) cpu_req = 0;
    else if (!cpu_req && $urandom_range(3) == 0) begin
      cpu_req = 1; cpu_rw = 1'($urandom_range(1));
      cpu_addr = 8'($urandom_range(15)); cpu_wdata = 8'($urandom);
    end
    if (e_dma_ack) dma_req = 0;
    else if (!dma_req && $urandom_range(3) == 0) begin
      dma_req = 1; dma_rw = 1'($urandom_range(1));
      dma_addr = 8'($urandom_range(15)); dma_wdata = 8'($urandom);
    end
    if (m_on) begin
      if (m_acc == 0) hit_delay = ($urandom_range(7) == 0) ? 99 : int'($urandom_range(4));
      ch_hit = (m_acc == hit_delay);
    end else begin
      ch_hit = ($urandom_range(3) == 0);  // stray hits while idle must be ignored
    end
    err_clr = ($urandom_range(15) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int en_cnt;
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h05] = 8'hA7;
    g_clr = 0; cpu_req = 0; cpu_rw = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_rw = 0; dma_addr = '0; dma_wdata = '0; ch_hit = 0; err_clr = 0;
    model_reset();
    step();
    step();
    chk("rst_owner",   32'(owner),    32'd1);
    chk("rst_ch_addr", 32'(ch_addr),  32'd0);
    chk("rst_ch_en",   32'(ch_en),    32'd0);
    chk("rst_rdata",   32'(cpu_rdata), 32'd0);
    g_clr = 1;

    // 1: zero-wait CPU read
    cpu_rw = 0; cpu_addr = 8'h05; cpu_req = 1;
    step();
    ch_hit = 1;
    step();
    chk("t1_cpu_ack",   32'(cpu_ack),   32'd1);
    chk("t1_cpu_rdata", 32'(cpu_rdata), 32'hA7);
    chk("t1_dma_ack",   32'(dma_ack),   32'd0);
    cpu_req = 0; ch_hit = 0;
    step();

    // 2: simultaneous requests after reset alternate CPU, DMA, CPU, DMA
    g_clr = 0; step(); g_clr = 1;
    cpu_rw = 0; cpu_addr = 8'h01; dma_rw = 0; dma_addr = 8'h02;
    ack_q.delete();
    cpu_req = 1; dma_req = 1;
    serve(50, 0);
    cpu_req = 1; dma_req = 1;
    serve(50, 0);
    chk("t2_n_acks", 32'(ack_q.size()), 32'd4);
    if (ack_q.size() == 4) begin
      chk("t2_order0", 32'(ack_q[0]), 32'd0);
      chk("t2_order1", 32'(ack_q[1]), 32'd1);
      chk("t2_order2", 32'(ack_q[2]), 32'd0);
      chk("t2_order3", 32'(ack_q[3]), 32'd1);
    end

    // 3: DMA write with four miss cycles
    dma_rw = 1; dma_addr = 8'h0E; dma_wdata = 8'h3C; dma_req = 1; ch_hit = 0;
    step();
    en_cnt = 0;
    for (int i = 0; i < 40 && ch_en; i++) begin
      en_cnt++;
      chk("t3_wdata", 32'(ch_wdata), 32'h3C);
      ch_hit = (en_cnt == 5);
      step();
    end
    chk("t3_en_cycles", 32'(en_cnt),      32'd5);
    chk("t3_dma_ack",   32'(dma_ack),     32'd1);
    chk("t3_no_err",    32'(timeout_err), 32'd0);
    dma_req = 0; ch_hit = 0;
    step();

    // 4: CPU read that never hits times out
    cpu_rw = 0; cpu_addr = 8'h03; cpu_req = 1;
    step();
    n = 0;
    while (!cpu_ack && n < 40) begin step(); n++; end
    chk("t4_cycles",    32'(n),           32'd32);
    chk("t4_err",       32'(timeout_err), 32'd1);
    chk("t4_rdata",     32'(cpu_rdata),   32'd0);
    chk("t4_wait_sat",  32'(wait_cnt),    32'd31);
    cpu_req = 0; err_clr = 1;
    step();
    err_clr = 0;
    chk("t4_err_clr", 32'(timeout_err), 32'd0);

    // 5: reset in the middle of an access, request still held
    cpu_rw = 0; cpu_addr = 8'h05; cpu_req = 1;
    step();
    step();
    g_clr = 0;
    #1;
    chk("t5_ch_en_async", 32'(ch_en), 32'd0);
    chk("t5_busy_async",  32'(busy),  32'd0);
    model_reset();
    step();
    g_clr = 1;
    ack_q.delete();
    serve(50, 1);
    chk("t5_regrant", 32'(ack_q.size()), 32'd1);
    chk("t5_rdata",   32'(cpu_rdata),    32'hA7);

    // 6: stray hits while idle, then a CPU write keeps cpu_rdata
    ch_hit = 1;
    step();
    chk("t6_no_ack_a", 32'(cpu_ack | dma_ack), 32'd0);
    step();
    chk("t6_no_ack_b", 32'(cpu_ack | dma_ack), 32'd0);
    ch_hit = 0;
    cpu_rw = 1; cpu_addr = 8'h05; cpu_wdata = 8'h55; cpu_req = 1;
    ack_q.delete();
    serve(50, 1);
    chk("t6_one_ack",    32'(ack_q.size()), 32'd1);
    chk("t6_rdata_kept", 32'(cpu_rdata),    32'hA7);

    // Randomized traffic from both requesters
    repeat (3000) begin
      drive_random();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
